state_checker: RTL and testbench

STATE_CHECKER -- requirements
Module: state_checker

---
 rtl/state_pkg.sv | 28 ++
 rtl/state_checker_if.sv | 23 ++
 rtl/sat_counter.sv | 33 +++
 rtl/state_checker.sv | 71 +++++++
 tb/tb_state_checker.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/state_pkg.sv
// Shared codes for the rotating 3-state sequencer and the checker FSM that watches it.
package state_pkg;

   localparam logic [3:0] STATE_0 = 4'd0;
   localparam logic [3:0] STATE_1 = 4'd1;
   localparam logic [3:0] STATE_2 = 4'd2;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      FAULT    = 2'd2
   } chk_state_e;

   function automatic logic is_legal(input logic [3:0] s);
      return (s == STATE_0) || (s == STATE_1) || (s == STATE_2);
   endfunction

   // Illegal codes map to themselves; callers also gate on is_legal().
   function automatic logic [3:0] successor(input logic [3:0] s);
      case (s)
         STATE_0: return STATE_1;
         STATE_1: return STATE_2;
         STATE_2: return STATE_0;
         default: return s;
      endcase
   endfunction

endpackage

// File: rtl/state_checker_if.sv
// Observation/status bundle between the sequencer-side driver and the checker.
interface state_checker_if #(parameter int CNT_W = 8);

   logic [3:0]       i_state;
   logic             i_clr;
   logic             o_locked;
   logic             o_err;
   logic             o_err_sticky;
   logic [CNT_W-1:0] o_cycle_cnt;
   logic [CNT_W-1:0] o_err_cnt;
   logic [3:0]       o_prev_state;

   modport master (
      output i_state, i_clr,
      input  o_locked, o_err, o_err_sticky, o_cycle_cnt, o_err_cnt, o_prev_state
   );

   modport slave (
      input  i_state, i_clr,
      output o_locked, o_err, o_err_sticky, o_cycle_cnt, o_err_cnt, o_prev_state
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear; optionally saturates at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Clear has priority over a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr)
         cnt_d = '0;
      else if (i_inc && !(SAT && (&cnt_q)))
         cnt_d = WIDTH'(cnt_q + 1'b1);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/state_checker.sv
// Watches a 0->1->2->0 sequencer, locks on STATE_0, flags illegal steps one cycle later.
module state_checker
   import state_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   state_checker_if.slave  bus
);

   chk_state_e state_q, state_d;
   logic [3:0] prev_q, prev_d;
   logic       err_q, err_d;
   logic       sticky_q, sticky_d;
   logic       step_ok, viol, rot;

   always_comb begin
      step_ok  = is_legal(bus.i_state) &&
                 ((bus.i_state == prev_q) || (bus.i_state == successor(prev_q)));
      viol     = (state_q == LOCKED) && !step_ok;
      rot      = (state_q == LOCKED) && (prev_q == STATE_2) && (bus.i_state == STATE_0);
      state_d  = state_q;
      prev_d   = bus.i_state;
      err_d    = viol;
      sticky_d = bus.i_clr ? 1'b0 : (sticky_q | viol);
      // UNLOCKED and FAULT both resync on the first STATE_0 and never flag.
      case (state_q)
         UNLOCKED,
         FAULT:   if (bus.i_state == STATE_0) state_d = LOCKED;
         LOCKED:  if (viol) state_d = FAULT;
         default: state_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= UNLOCKED;
         prev_q   <= STATE_0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W), .SAT(1'b1)) u_err_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (viol),
      .i_clr   (bus.i_clr),
      .o_cnt   (bus.o_err_cnt)
   );

   sat_counter #(.WIDTH(CNT_W), .SAT(1'b0)) u_cycle_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (rot),
      .i_clr   (bus.i_clr),
      .o_cnt   (bus.o_cycle_cnt)
   );

   assign bus.o_locked     = (state_q == LOCKED);
   assign bus.o_err        = err_q;
   assign bus.o_err_sticky = sticky_q;
   assign bus.o_prev_state = prev_q;

endmodule

// File: tb/tb_state_checker.sv
// Bench for state_checker: directed vector table, corner sequences, random run vs reference model.
module tb_state_checker;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [3:0] st;
   logic       clr;

   always #5 i_clk = ~i_clk;

   state_checker_if #(.CNT_W(8)) bus8 ();
   state_checker_if #(.CNT_W(2)) bus2 ();

   assign bus8.i_state = st;
   assign bus8.i_clr   = clr;
   assign bus2.i_state = st;
   assign bus2.i_clr   = clr;

   state_checker #(.CNT_W(8)) u_dut8 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus8));
   state_checker #(.CNT_W(2)) u_dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus2));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: mode 0=searching, 1=tracking, 2=faulted
   int m_mode, m_prev, m_err, m_sticky, m_cyc8, m_errc8, m_cyc2, m_errc2;

   task automatic model_step(input bit r, input int s, input bit c);
      bit legal;
      int v, rt;
      if (!r) begin
         m_mode = 0; m_prev = 0; m_err = 0; m_sticky = 0;
         m_cyc8 = 0; m_errc8 = 0; m_cyc2 = 0; m_errc2 = 0;
      end else begin
         legal = (s < 3) && (s == m_prev || s == (m_prev + 1) % 3);
         v  = (m_mode == 1 && !legal) ? 1 : 0;
         rt = (m_mode == 1 && m_prev == 2 && s == 0) ? 1 : 0;
         m_err    = v;
         m_sticky = c ? 0 : (m_sticky | v);
         m_errc8  = c ? 0 : ((v == 1 && m_errc8 < 255) ? m_errc8 + 1 : m_errc8);
         m_errc2  = c ? 0 : ((v == 1 && m_errc2 < 3) ? m_errc2 + 1 : m_errc2);
         m_cyc8   = c ? 0 : (m_cyc8 + rt) % 256;
         m_cyc2   = c ? 0 : (m_cyc2 + rt) % 4;
         if (m_mode == 1) m_mode = v ? 2 : 1;
         else if (s == 0) m_mode = 1;
         m_prev = s;
      end
   endtask

   task automatic model_check(input string tag);
      check({tag, " locked8"}, bus8.o_locked,     m_mode == 1);
      check({tag, " err8"},    bus8.o_err,        m_err);
      check({tag, " sticky8"}, bus8.o_err_sticky, m_sticky);
      check({tag, " cyc8"},    bus8.o_cycle_cnt,  m_cyc8);
      check({tag, " errc8"},   bus8.o_err_cnt,    m_errc8);
      check({tag, " prev8"},   bus8.o_prev_state, m_prev);
      check({tag, " locked2"}, bus2.o_locked,     m_mode == 1);
      check({tag, " err2"},    bus2.o_err,        m_err);
      check({tag, " cyc2"},    bus2.o_cycle_cnt,  m_cyc2);
      check({tag, " errc2"},   bus2.o_err_cnt,    m_errc2);
   endtask

   task automatic cycle(input bit r, input int s, input bit c);
      i_rst_n = r;
      st      = 4'(s);
      clr     = c;
      @(posedge i_clk);
      model_step(r, s, c);
      #1;
   endtask

   typedef struct {
      bit rst_n; int st; bit clr;
      bit locked; bit err; bit sticky; int cyc; int errc; int prev;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, int s, bit c, bit l, bit e, bit sk, int cy, int ec, int pv);
      vec_t v;
      v.rst_n = r; v.st = s; v.clr = c; v.locked = l; v.err = e;
      v.sticky = sk; v.cyc = cy; v.errc = ec; v.prev = pv;
      return v;
   endfunction

   initial begin
      int cur;
      i_rst_n = 1'b0; st = 4'd0; clr = 1'b0;

      //                r  st c   L  E  S  cyc ec prev
      tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0));  // reset
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0,  0, 0));  // lock on first 0
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0,  0, 1));
      tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0,  0, 1));
      tbl.push_back(mk(1, 2, 0,  1, 0, 0, 0,  0, 2));
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 1,  0, 0));  // rotation
      tbl.push_back(mk(1, 2, 0,  0, 1, 1, 1,  1, 2));  // 0->2 violation
      tbl.push_back(mk(1, 1, 0,  0, 0, 1, 1,  1, 1));  // fault, no flag
      tbl.push_back(mk(1, 0, 0,  1, 0, 1, 1,  1, 0));  // resync
      tbl.push_back(mk(1, 2, 1,  0, 1, 0, 0,  0, 2));  // clear beats violation
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0,  0, 1));
      tbl.push_back(mk(1, 2, 0,  1, 0, 0, 0,  0, 2));
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 1,  0, 0));
      tbl.push_back(mk(1, 1, 0,  1, 0, 0, 1,  0, 1));
      tbl.push_back(mk(1, 2, 0,  1, 0, 0, 1,  0, 2));
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 2,  0, 0));
      tbl.push_back(mk(1, 1, 0,  1, 0, 0, 2,  0, 1));
      tbl.push_back(mk(1, 2, 0,  1, 0, 0, 2,  0, 2));
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 3,  0, 0));
      tbl.push_back(mk(0, 2, 1,  0, 0, 0, 0,  0, 0));  // reset drops violation
      tbl.push_back(mk(1, 1, 0,  0, 0, 0, 0,  0, 1));
      tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0,  0, 0));
      tbl.push_back(mk(1, 5, 0,  0, 1, 1, 0,  1, 5));  // illegal code
      tbl.push_back(mk(1, 5, 0,  0, 0, 1, 0,  1, 5));
      tbl.push_back(mk(1, 5, 0,  0, 0, 1, 0,  1, 5));
      tbl.push_back(mk(1, 0, 0,  1, 0, 1, 0,  1, 0));

      foreach (tbl[i]) begin
         cycle(tbl[i].rst_n, tbl[i].st, tbl[i].clr);
         check($sformatf("row%0d locked8", i), bus8.o_locked,     tbl[i].locked);
         check($sformatf("row%0d err8", i),    bus8.o_err,        tbl[i].err);
         check($sformatf("row%0d sticky8", i), bus8.o_err_sticky, tbl[i].sticky);
         check($sformatf("row%0d cyc8", i),    bus8.o_cycle_cnt,  tbl[i].cyc);
         check($sformatf("row%0d errc8", i),   bus8.o_err_cnt,    tbl[i].errc);
         check($sformatf("row%0d prev8", i),   bus8.o_prev_state, tbl[i].prev);
         check($sformatf("row%0d locked2", i), bus2.o_locked,     tbl[i].locked);
         check($sformatf("row%0d cyc2", i),    bus2.o_cycle_cnt,  tbl[i].cyc);
         check($sformatf("row%0d errc2", i),   bus2.o_err_cnt,    tbl[i].errc);
      end

      // Saturation and wrap: five violations with resync, then five rotations
      cycle(1, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 2, 0);
         check("sat err pulse", bus8.o_err, 1);
         cycle(1, 0, 0);
      end
      check("sat errc2", bus2.o_err_cnt, 3);
      check("sat errc8", bus8.o_err_cnt, 5);
      check("sat sticky", bus2.o_err_sticky, 1);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 1, 0);
         cycle(1, 2, 0);
         cycle(1, 0, 0);
      end
      check("wrap cyc2", bus2.o_cycle_cnt, 1);
      check("wrap cyc8", bus8.o_cycle_cnt, 5);
      model_check("post-directed");

      // Random run, mostly legal traffic with injected faults, clears and resets
      cur = 0;
      for (int n = 0; n < 3000; n++) begin
         bit r, c;
         int p, s;
         r = ($urandom_range(0, 99) != 0);
         c = ($urandom_range(0, 15) == 0);
         p = $urandom_range(0, 9);
         if (p < 6)      s = (cur < 3) ? (cur + 1) % 3 : 0;
         else if (p < 8) s = cur;
         else            s = $urandom_range(0, 15);
         cur = s;
         cycle(r, s, c);
         model_check($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
